// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control sequencer: Moore decode of state drives every datapath select/enable.
// Optional macro MCCTRL_MEM_WAIT_EN stretches FETCH/MEM_READ/MEM_WRITE until mem_ready is sampled high.
module mc_control_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             branch_ne,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             byte_store,
    output logic             ir_write,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             illegal_op,
    output logic [3:0]       state_dbg,
    output logic [CNT_W-1:0] retired
);

    localparam logic [5:0] OP_R    = 6'd0;
    localparam logic [5:0] OP_J    = 6'd2;
    localparam logic [5:0] OP_JAL  = 6'd3;
    localparam logic [5:0] OP_BEQ  = 6'd4;
    localparam logic [5:0] OP_BNE  = 6'd5;
    localparam logic [5:0] OP_ADDI = 6'd8;
    localparam logic [5:0] OP_SLTI = 6'd10;
    localparam logic [5:0] OP_ANDI = 6'd12;
    localparam logic [5:0] OP_ORI  = 6'd13;
    localparam logic [5:0] OP_LW   = 6'd35;
    localparam logic [5:0] OP_SB   = 6'd40;
    localparam logic [5:0] OP_SW   = 6'd43;
    localparam logic [5:0] FN_JR   = 6'd8;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_LW_WB     = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_IMM_EXEC  = 4'd10,
        S_IMM_WB    = 4'd11,
        S_JAL       = 4'd12,
        S_JR        = 4'd13,
        S_SPARE     = 4'd14,
        S_IDLE      = 4'd15
    } state_t;

    typedef enum logic [2:0] {
        C_MEM, C_R, C_JR, C_BR, C_J, C_JAL, C_IMM, C_ILL
    } iclass_t;

    state_t           state_q;
    state_t           state_nx;
    logic             illegal_q;
    logic             illegal_set;
    logic             retire;
    logic [CNT_W-1:0] retired_q;
    logic             mem_ok;
    iclass_t          iclass;

`ifdef MCCTRL_MEM_WAIT_EN
    assign mem_ok = mem_ready;
`else
    logic mem_ready_unused;
    assign mem_ready_unused = mem_ready;
    assign mem_ok = 1'b1;
`endif

    function automatic iclass_t classify(input logic [5:0] op, input logic [5:0] fn);
        iclass_t c;
        case (op)
            OP_LW, OP_SW, OP_SB:             c = C_MEM;
            OP_R:                            c = (fn == FN_JR) ? C_JR : C_R;
            OP_BEQ, OP_BNE:                  c = C_BR;
            OP_J:                            c = C_J;
            OP_JAL:                          c = C_JAL;
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: c = C_IMM;
            default:                         c = C_ILL;
        endcase
        return c;
    endfunction

    function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
        logic [2:0] a;
        case (op)
            OP_SLTI: a = 3'b011;
            OP_ANDI: a = 3'b100;
            OP_ORI:  a = 3'b101;
            default: a = 3'b000;
        endcase
        return a;
    endfunction

    assign iclass = classify(opcode, funct);

    // State register, sticky illegal flag and retired-instruction counter
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q <= state_nx;
            if (illegal_set)
                illegal_q <= 1'b1;
            if (retire)
                retired_q <= retired_q + CNT_W'(1);
        end
    end

    // Next state; retire marks the final state of a legal instruction
    always_comb begin
        state_nx    = S_FETCH;
        illegal_set = 1'b0;
        retire      = 1'b0;
        case (state_q)
            S_IDLE:  state_nx = S_FETCH;
            S_FETCH: state_nx = mem_ok ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (iclass)
                    C_MEM: state_nx = S_MEM_ADDR;
                    C_R:   state_nx = S_R_EXEC;
                    C_JR:  state_nx = S_JR;
                    C_BR:  state_nx = S_BRANCH;
                    C_J:   state_nx = S_JUMP;
                    C_JAL: state_nx = S_JAL;
                    C_IMM: state_nx = S_IMM_EXEC;
                    default: begin
                        state_nx    = S_FETCH;
                        illegal_set = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: state_nx = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ: state_nx = mem_ok ? S_LW_WB : S_MEM_READ;
            S_MEM_WRITE: begin
                state_nx = mem_ok ? S_FETCH : S_MEM_WRITE;
                retire   = mem_ok;
            end
            S_R_EXEC:   state_nx = S_R_WB;
            S_IMM_EXEC: state_nx = S_IMM_WB;
            S_LW_WB, S_R_WB, S_BRANCH, S_JUMP, S_IMM_WB, S_JAL, S_JR: begin
                state_nx = S_FETCH;
                retire   = 1'b1;
            end
            default: begin
                state_nx    = S_FETCH;
                illegal_set = 1'b1;
            end
        endcase
    end

    // Moore output decode; IR-derived fields only refine the current state's controls
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        byte_store    = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 2'b00;
        mem_to_reg    = 2'b00;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 3'b000;
        pc_source     = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                ir_write  = mem_ok;
                pc_write  = mem_ok;
                alu_src_b = 2'b01;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_LW_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
            end
            S_MEM_WRITE: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                byte_store = (opcode == OP_SB);
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 3'b010;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 2'b01;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 3'b001;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                branch_ne     = (opcode == OP_BNE);
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            S_IMM_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = imm_alu_op(opcode);
            end
            S_IMM_WB: reg_write = 1'b1;
            S_JAL: begin
                reg_write  = 1'b1;
                reg_dst    = 2'b10;
                mem_to_reg = 2'b10;
                pc_write   = 1'b1;
                pc_source  = 2'b10;
            end
            S_JR: begin
                pc_write  = 1'b1;
                pc_source = 2'b11;
            end
            default: ;
        endcase
    end

    assign illegal_op = illegal_q;
    assign state_dbg  = state_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: directed table, hand-written corner sequences and randomized
// instruction streams checked against an instruction-level model.
module tb_mc_control_fsm;

    localparam int CNT_W = 4;
`ifdef MCCTRL_MEM_WAIT_EN
    localparam int EXP_LW_CYC = 8;
    localparam int EXP_MR_CYC = 4;
`else
    localparam int EXP_LW_CYC = 5;
    localparam int EXP_MR_CYC = 1;
`endif

    logic             clock = 1'b0;
    logic             reset_n;
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             mem_ready;
    logic             pc_write, pc_write_cond, branch_ne, i_or_d;
    logic             mem_read, mem_write, byte_store, ir_write;
    logic [1:0]       reg_dst, mem_to_reg;
    logic             reg_write, alu_src_a;
    logic [1:0]       alu_src_b;
    logic [2:0]       alu_op;
    logic [1:0]       pc_source;
    logic             illegal_op;
    logic [3:0]       state_dbg;
    logic [CNT_W-1:0] retired;

    mc_control_fsm #(.CNT_W(CNT_W)) dut (
        .clock(clock), .reset_n(reset_n), .opcode(opcode), .funct(funct),
        .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .branch_ne(branch_ne), .i_or_d(i_or_d), .mem_read(mem_read),
        .mem_write(mem_write), .byte_store(byte_store), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .illegal_op(illegal_op), .state_dbg(state_dbg),
        .retired(retired)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    logic [CNT_W-1:0] exp_ret;
    logic             exp_ill;

    int         obs_len, obs_regw, obs_memw, obs_memr, obs_pcw, obs_pcc, obs_irw;
    logic [31:0] obs_path;
    logic [1:0] obs_dst, obs_m2r, obs_pcsrc;
    logic       obs_bs, obs_bne;
    logic [2:0] obs_aop;

    int         mdl_len, mdl_regw, mdl_memw, mdl_memr, mdl_pcw, mdl_pcc;
    logic [31:0] mdl_path;
    logic [1:0] mdl_dst, mdl_m2r;
    logic       mdl_bad;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        int         len;
        logic [3:0] last;
        logic [1:0] dst;
        logic [1:0] m2r;
        logic       inc;
        logic       ill;
    } vec_t;

    vec_t tbl[14];
    logic [5:0] legal_ops[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    function automatic logic [20:0] ctrl_vec();
        return {pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, byte_store,
                ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};
    endfunction

    // Runs one instruction from a FETCH negedge back to the next FETCH, recording what it did
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn);
        opcode = op;
        funct  = fn;
        obs_len = 0; obs_path = '0;
        obs_regw = 0; obs_memw = 0; obs_memr = 0; obs_pcw = 0; obs_pcc = 0; obs_irw = 0;
        obs_dst = 2'b00; obs_m2r = 2'b00; obs_pcsrc = 2'b00;
        obs_bs = 1'b0; obs_bne = 1'b0; obs_aop = 3'b000;
        do begin
            if (obs_len < 8) obs_path[obs_len*4 +: 4] = state_dbg;
            obs_len++;
            if (reg_write)     begin obs_regw++; obs_dst = reg_dst; obs_m2r = mem_to_reg; end
            if (mem_write)     begin obs_memw++; obs_bs = byte_store; end
            if (mem_read)      obs_memr++;
            if (ir_write)      obs_irw++;
            if (pc_write)      begin obs_pcw++; if (state_dbg != 4'd0) obs_pcsrc = pc_source; end
            if (pc_write_cond) begin obs_pcc++; obs_bne = branch_ne; end
            if (state_dbg == 4'd10) obs_aop = alu_op;
            @(negedge clock);
        end while (state_dbg != 4'd0 && obs_len < 20);
    endtask

    // Instruction-level expectations: list of phases and per-instruction strobe counts
    task automatic model_instr(input logic [5:0] op, input logic [5:0] fn);
        int st[$];
        st.push_back(0);
        st.push_back(1);
        mdl_regw = 0; mdl_memw = 0; mdl_memr = 1; mdl_pcw = 1; mdl_pcc = 0;
        mdl_dst = 2'b00; mdl_m2r = 2'b00; mdl_bad = 1'b0;
        if (op == 35) begin
            st.push_back(2); st.push_back(3); st.push_back(4);
            mdl_regw = 1; mdl_memr = 2; mdl_m2r = 2'b01;
        end else if (op == 43 || op == 40) begin
            st.push_back(2); st.push_back(5); mdl_memw = 1;
        end else if (op == 0 && fn == 8) begin
            st.push_back(13); mdl_pcw = 2;
        end else if (op == 0) begin
            st.push_back(6); st.push_back(7); mdl_regw = 1; mdl_dst = 2'b01;
        end else if (op == 4 || op == 5) begin
            st.push_back(8); mdl_pcc = 1;
        end else if (op == 2) begin
            st.push_back(9); mdl_pcw = 2;
        end else if (op == 3) begin
            st.push_back(12); mdl_pcw = 2; mdl_regw = 1; mdl_dst = 2'b10; mdl_m2r = 2'b10;
        end else if (op == 8 || op == 10 || op == 12 || op == 13) begin
            st.push_back(10); st.push_back(11); mdl_regw = 1;
        end else begin
            mdl_bad = 1'b1;
        end
        mdl_len  = st.size();
        mdl_path = '0;
        foreach (st[i]) mdl_path[i*4 +: 4] = 4'(st[i]);
    endtask

    task automatic run_and_check(input logic [5:0] op, input logic [5:0] fn);
        string t;
        logic [2:0] exp_aop;
        t = $sformatf("op%0d/fn%0d", op, fn);
        model_instr(op, fn);
        run_instr(op, fn);
        check({t, ".len"},  obs_len,  mdl_len);
        check({t, ".path"}, obs_path, mdl_path);
        check({t, ".reg_write_cnt"}, obs_regw, mdl_regw);
        check({t, ".mem_write_cnt"}, obs_memw, mdl_memw);
        check({t, ".mem_read_cnt"},  obs_memr, mdl_memr);
        check({t, ".pc_write_cnt"},  obs_pcw,  mdl_pcw);
        check({t, ".pc_cond_cnt"},   obs_pcc,  mdl_pcc);
        check({t, ".ir_write_cnt"},  obs_irw,  1);
        if (mdl_regw > 0) begin
            check({t, ".reg_dst"},    obs_dst, mdl_dst);
            check({t, ".mem_to_reg"}, obs_m2r, mdl_m2r);
        end
        if (mdl_memw > 0) check({t, ".byte_store"}, obs_bs, op == 6'd40);
        if (mdl_pcc > 0)  check({t, ".branch_ne"}, obs_bne, op == 6'd5);
        if (op == 8 || op == 10 || op == 12 || op == 13) begin
            exp_aop = (op == 10) ? 3'b011 : (op == 12) ? 3'b100 : (op == 13) ? 3'b101 : 3'b000;
            check({t, ".imm_alu_op"}, obs_aop, exp_aop);
        end
        if (!mdl_bad) exp_ret = exp_ret + 1'b1;
        exp_ill = exp_ill | mdl_bad;
        check({t, ".retired"},    retired,    exp_ret);
        check({t, ".illegal_op"}, illegal_op, exp_ill);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc, n3, r;
        logic [3:0] last;
        logic [5:0] rop, rfn;

        tbl[0]  = '{6'd35, 6'd0,  5, 4'd4,  2'b00, 2'b01, 1'b1, 1'b0};
        tbl[1]  = '{6'd43, 6'd0,  4, 4'd5,  2'b00, 2'b00, 1'b1, 1'b0};
        tbl[2]  = '{6'd40, 6'd0,  4, 4'd5,  2'b00, 2'b00, 1'b1, 1'b0};
        tbl[3]  = '{6'd0,  6'd32, 4, 4'd7,  2'b01, 2'b00, 1'b1, 1'b0};
        tbl[4]  = '{6'd0,  6'd8,  3, 4'd13, 2'b00, 2'b00, 1'b1, 1'b0};
        tbl[5]  = '{6'd4,  6'd0,  3, 4'd8,  2'b00, 2'b00, 1'b1, 1'b0};
        tbl[6]  = '{6'd5,  6'd0,  3, 4'd8,  2'b00, 2'b00, 1'b1, 1'b0};
        tbl[7]  = '{6'd2,  6'd0,  3, 4'd9,  2'b00, 2'b00, 1'b1, 1'b0};
        tbl[8]  = '{6'd3,  6'd0,  3, 4'd12, 2'b10, 2'b10, 1'b1, 1'b0};
        tbl[9]  = '{6'd8,  6'd0,  4, 4'd11, 2'b00, 2'b00, 1'b1, 1'b0};
        tbl[10] = '{6'd10, 6'd0,  4, 4'd11, 2'b00, 2'b00, 1'b1, 1'b0};
        tbl[11] = '{6'd12, 6'd0,  4, 4'd11, 2'b00, 2'b00, 1'b1, 1'b0};
        tbl[12] = '{6'd13, 6'd0,  4, 4'd11, 2'b00, 2'b00, 1'b1, 1'b0};
        tbl[13] = '{6'd63, 6'd0,  2, 4'd1,  2'b00, 2'b00, 1'b0, 1'b1};
        legal_ops = '{6'd0, 6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd8, 6'd10, 6'd12, 6'd13,
                      6'd35, 6'd40, 6'd43};

        reset_n = 1'b0; opcode = 6'd0; funct = 6'd0; mem_ready = 1'b1;
        exp_ret = '0; exp_ill = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("reset.state", state_dbg, 4'd15);
        check("reset.ctrl", ctrl_vec(), 21'd0);
        check("reset.retired", retired, 0);
        check("reset.illegal", illegal_op, 0);
        reset_n = 1'b1;
        @(negedge clock);
        check("release.state", state_dbg, 4'd0);

        for (int i = 0; i < 14; i++) begin
            run_instr(tbl[i].op, tbl[i].fn);
            last = (obs_len >= 1 && obs_len <= 8) ? obs_path[(obs_len-1)*4 +: 4] : 4'hF;
            if (tbl[i].inc) exp_ret = exp_ret + 1'b1;
            exp_ill = exp_ill | tbl[i].ill;
            check($sformatf("tbl%0d.len", i), obs_len, tbl[i].len);
            check($sformatf("tbl%0d.last_state", i), last, tbl[i].last);
            check($sformatf("tbl%0d.reg_dst", i), obs_dst, tbl[i].dst);
            check($sformatf("tbl%0d.mem_to_reg", i), obs_m2r, tbl[i].m2r);
            check($sformatf("tbl%0d.retired", i), retired, exp_ret);
            check($sformatf("tbl%0d.illegal", i), illegal_op, exp_ill);
        end

        // Reset in the middle of an R-type execute
        opcode = 6'd0; funct = 6'd32;
        @(negedge clock);
        @(negedge clock);
        check("midreset.pre_state", state_dbg, 4'd6);
        reset_n = 1'b0;
        #1;
        check("midreset.state", state_dbg, 4'd15);
        check("midreset.ctrl", ctrl_vec(), 21'd0);
        check("midreset.retired", retired, 0);
        check("midreset.illegal", illegal_op, 0);
        exp_ret = '0; exp_ill = 1'b0;
        @(negedge clock);
        check("midreset.hold", state_dbg, 4'd15);
        reset_n = 1'b1;
        @(negedge clock);
        check("midreset.fetch", state_dbg, 4'd0);

        // BNE with exact per-state control vectors
        opcode = 6'd5; funct = 6'd0;
        check("bne.fetch_ctrl", ctrl_vec(),
              {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0,
               2'b01, 3'b000, 2'b00});
        @(negedge clock);
        check("bne.decode_state", state_dbg, 4'd1);
        check("bne.decode_ctrl", ctrl_vec(),
              {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0,
               2'b11, 3'b000, 2'b00});
        @(negedge clock);
        check("bne.branch_state", state_dbg, 4'd8);
        check("bne.branch_ctrl", ctrl_vec(),
              {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1,
               2'b00, 3'b001, 2'b01});
        @(negedge clock);
        exp_ret = exp_ret + 1'b1;
        check("bne.back_to_fetch", state_dbg, 4'd0);
        check("bne.retired", retired, exp_ret);

        // JAL then JR
        run_and_check(6'd3, 6'd0);
        check("jal.pc_source", obs_pcsrc, 2'b10);
        run_and_check(6'd0, 6'd8);
        check("jr.pc_source", obs_pcsrc, 2'b11);
        check("jal_jr.retired", retired, 4'd3);

        // Illegal opcode is sticky across a following ADDI and does not retire
        run_and_check(6'd63, 6'd0);
        check("illegal.retired_unchanged", retired, 4'd3);
        run_and_check(6'd8, 6'd0);
        check("illegal.sticky", illegal_op, 1'b1);

        // LW with mem_ready low for the first three MEM_READ cycles
        opcode = 6'd35; funct = 6'd0; cyc = 0; n3 = 0;
        do begin
            mem_ready = (state_dbg == 4'd3 && n3 < 3) ? 1'b0 : 1'b1;
            if (state_dbg == 4'd3) n3++;
            cyc++;
            @(negedge clock);
        end while (state_dbg != 4'd0 && cyc < 30);
        mem_ready = 1'b1;
        exp_ret = exp_ret + 1'b1;
        check("lw_wait.cycles", cyc, EXP_LW_CYC);
        check("lw_wait.mem_read_cycles", n3, EXP_MR_CYC);
        check("lw_wait.retired", retired, exp_ret);

        // Randomized instruction stream; retired wraps through its 4-bit range
        for (int k = 0; k < 300; k++) begin
            r = $urandom_range(0, 15);
            rop = (r < 13) ? legal_ops[r] : 6'($urandom);
            rfn = ($urandom_range(0, 3) == 0) ? 6'd8 : 6'($urandom);
            run_and_check(rop, rfn);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
